// File: rtl/ysyx_25060170_fetch_ctrl_pkg.sv
// Shared widths, fetch FSM state encoding and response-buffer layout for the
// ysyx_25060170 fetch sequencer.
package ysyx_25060170_fetch_ctrl_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_HOLD = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              err;
  } fetch_buf_t;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [PC_W-1:0] pc_seq_next(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ysyx_25060170_redirect_arb.sv
// Fixed-priority redirect arbiter: the oldest stage (LS, then EX, then ID)
// wins. Targets pass through untouched.
module ysyx_25060170_redirect_arb
  import ysyx_25060170_fetch_ctrl_pkg::*;
(
  input  logic            ls_pc_jump,
  input  logic [PC_W-1:0] ls_pc_i,
  input  logic            ie_pc_jump,
  input  logic [PC_W-1:0] ie_pc_i,
  input  logic            id_pc_jump,
  input  logic [PC_W-1:0] id_pc_i,
  output logic            redir,
  output logic [PC_W-1:0] redir_pc
);

  always_comb begin
    redir    = ls_pc_jump | ie_pc_jump | id_pc_jump;
    redir_pc = '0;
    if (ls_pc_jump) begin
      redir_pc = ls_pc_i;
    end else if (ie_pc_jump) begin
      redir_pc = ie_pc_i;
    end else if (id_pc_jump) begin
      redir_pc = id_pc_i;
    end
  end

endmodule

// File: rtl/ysyx_25060170_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps at most one imem request in
// flight, squashes responses made stale by redirects and buffers one result.
//
// state | meaning
// IDLE  | post-reset bubble, request starts next cycle
// REQ   | imem_req_valid high, waiting for handshake
// WAIT  | request accepted, response still wanted
// DROP  | request accepted, response will be discarded
// HOLD  | buffered instruction offered to IF stage
module ysyx_25060170_fetch_ctrl
  import ysyx_25060170_fetch_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_pc_jump,
  input  logic [PC_W-1:0]   ls_pc_i,
  input  logic              ie_pc_jump,
  input  logic [PC_W-1:0]   ie_pc_i,
  input  logic              id_pc_jump,
  input  logic [PC_W-1:0]   id_pc_i,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              if_valid,
  input  logic              if_ready,
  input  logic              id_stall,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_err
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  fetch_buf_t      buf_q, buf_d;

  logic            redir;
  logic [PC_W-1:0] redir_pc;
  logic            accept;

  ysyx_25060170_redirect_arb u_redirect_arb (
    .ls_pc_jump (ls_pc_jump),
    .ls_pc_i    (ls_pc_i),
    .ie_pc_jump (ie_pc_jump),
    .ie_pc_i    (ie_pc_i),
    .id_pc_jump (id_pc_jump),
    .id_pc_i    (id_pc_i),
    .redir      (redir),
    .redir_pc   (redir_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    accept         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redir) begin
          pc_d = redir_pc;
        end
      end

      ST_REQ: begin
        imem_req_valid = 1'b1;
        if (redir) begin
          // A handshake coinciding with a redirect fetched the old address;
          // its response must still be drained.
          pc_d = redir_pc;
          if (imem_req_ready) begin
            state_d = ST_DROP;
          end
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (redir) begin
            pc_d    = redir_pc;
            state_d = ST_REQ;
          end else begin
            buf_d.pc   = pc_q;
            buf_d.inst = imem_rsp_data;
            buf_d.err  = imem_rsp_err;
            state_d    = ST_HOLD;
          end
        end else if (redir) begin
          pc_d    = redir_pc;
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        if (redir) begin
          pc_d = redir_pc;
        end
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end

      ST_HOLD: begin
        if_valid = !redir;
        accept   = if_ready && !id_stall;
        if (redir) begin
          pc_d    = redir_pc;
          state_d = ST_REQ;
        end else if (accept) begin
          pc_d    = pc_seq_next(pc_q);
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req_addr = pc_q;
  assign if_pc         = buf_q.pc;
  assign if_inst       = buf_q.inst;
  assign if_err        = buf_q.err;

endmodule

// File: tb/tb_ysyx_25060170_fetch_ctrl.sv
// Self-checking bench for the fetch sequencer: directed scenarios plus a
// randomized run against a PC-level reference model and a one-deep memory.
module tb_ysyx_25060170_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_pc_jump, ie_pc_jump, id_pc_jump;
  logic [31:0] ls_pc_i, ie_pc_i, id_pc_i;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        if_valid, if_ready, id_stall;
  logic [31:0] if_pc, if_inst;
  logic        if_err;

  int checks   = 0;
  int failures = 0;

  // memory model state
  logic        mem_busy = 1'b0;
  int          mem_dly  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          dly_cfg  = 0;
  logic        rdy_en   = 1'b1;

  // values sampled mid-cycle by step()
  logic        s_req_valid, s_if_valid, s_if_err, s_hs, s_rsp;
  logic [31:0] s_req_addr, s_if_pc, s_if_inst;

  always #5 clk = ~clk;

  ysyx_25060170_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ls_pc_jump     (ls_pc_jump),
    .ls_pc_i        (ls_pc_i),
    .ie_pc_jump     (ie_pc_jump),
    .ie_pc_i        (ie_pc_i),
    .id_pc_jump     (id_pc_jump),
    .id_pc_i        (id_pc_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .id_stall       (id_stall),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_err         (if_err)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a ^ 32'h5A5A_1234) + {a[15:0], a[31:16]};
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[31:24] == 8'hA0;
  endfunction

  task automatic clear_jumps();
    ls_pc_jump = 1'b0; ie_pc_jump = 1'b0; id_pc_jump = 1'b0;
  endtask

  // One clock cycle: drive memory, sample DUT mid-cycle, clock, update memory.
  task automatic step();
    imem_rsp_valid = mem_busy && (mem_dly == 0);
    imem_rsp_data  = imem_rsp_valid ? inst_of(mem_addr) : 32'h0;
    imem_rsp_err   = imem_rsp_valid && err_of(mem_addr);
    imem_req_ready = rdy_en && !mem_busy;
    #2;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_inst   = if_inst;
    s_if_err    = if_err;
    s_hs        = imem_req_valid && imem_req_ready;
    s_rsp       = imem_rsp_valid;
    @(posedge clk);
    #1;
    if (s_rsp) mem_busy = 1'b0;
    else if (mem_busy && mem_dly > 0) mem_dly--;
    if (s_hs) begin
      mem_busy = 1'b1;
      mem_addr = s_req_addr;
      mem_dly  = dly_cfg;
    end
    imem_rsp_valid = 1'b0;
  endtask

  task automatic wait_hold(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_if_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    clear_jumps();
    if_ready = 1'b0; id_stall = 1'b0;
    rst = 1'b1;
    mem_busy = 1'b0;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_jumps();
    if_ready = 1'b0; id_stall = 1'b0; rdy_en = 1'b1; dly_cfg = 0;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, if_valid, if_err} !== 3'b000 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got req_valid=%b if_valid=%b if_err=%b if_pc=%h if_inst=%h, want all 0",
               imem_req_valid, if_valid, if_err, if_pc, if_inst);
    end
    checks++;
    if (imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_pc got=%h want=%h", imem_req_addr, RESET_PC);
    end
    rst = 1'b0;
    #1;
    step();
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b want=0", s_req_valid);
    end
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL first_req got valid=%b addr=%h want 1/80000000", s_req_valid, s_req_addr);
    end
    step();
    checks++;
    if (s_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_not_valid got=%b want=0", s_if_valid);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    checks++;
    if (s_if_valid !== 1'b1 || s_if_pc !== 32'h8000_0000 || s_if_inst !== 32'h0000_0413 || s_if_err !== 1'b0) begin
      failures++;
      $display("FAIL first_inst got valid=%b pc=%h inst=%h err=%b want 1/80000000/00000413/0",
               s_if_valid, s_if_pc, s_if_inst, s_if_err);
    end
    rdy_en = 1'b0;
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0004) begin
      failures++;
      $display("FAIL seq_req got valid=%b addr=%h want 1/80000004", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_redir_prio();
    bit ok;
    logic [31:0] want [3];
    want[0] = 32'h8000_0100; want[1] = 32'h8000_0180; want[2] = 32'h8000_01C0;
    rdy_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin ls_pc_jump = 1'b1; ls_pc_i = 32'h8000_0100; id_pc_jump = 1'b1; id_pc_i = 32'h8000_0200; end
        1: begin ie_pc_jump = 1'b1; ie_pc_i = 32'h8000_0180; id_pc_jump = 1'b1; id_pc_i = 32'h8000_0280; end
        default: begin ls_pc_jump = 1'b1; ls_pc_i = 32'h8000_01C0; ie_pc_jump = 1'b1; ie_pc_i = 32'h8000_0190; end
      endcase
      step();
      clear_jumps();
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== want[k]) begin
        failures++;
        $display("FAIL redir_prio_%0d got valid=%b addr=%h want 1/%h", k, s_req_valid, s_req_addr, want[k]);
      end
    end
    rdy_en = 1'b1;
    wait_hold(ok);
    checks++;
    if (!ok || s_if_pc !== 32'h8000_01C0 || s_if_inst !== inst_of(32'h8000_01C0)) begin
      failures++;
      $display("FAIL redir_fetch got ok=%b pc=%h inst=%h want 1/800001c0/%h", ok, s_if_pc, s_if_inst, inst_of(32'h8000_01C0));
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_wait_redirect();
    bit ok;
    int leaks = 0;
    rdy_en = 1'b1; dly_cfg = 3;
    step();
    id_pc_jump = 1'b1; id_pc_i = 32'h8000_0040;
    step();
    clear_jumps();
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_if_valid !== 1'b0 || s_req_valid !== 1'b0) leaks++;
    end
    checks++;
    if (leaks != 0 || mem_busy) begin
      failures++;
      $display("FAIL stale_drop got leaks=%0d busy=%b want 0/0", leaks, mem_busy);
    end
    dly_cfg = 0;
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0040) begin
      failures++;
      $display("FAIL after_drop_req got valid=%b addr=%h want 1/80000040", s_req_valid, s_req_addr);
    end
    wait_hold(ok);
    checks++;
    if (!ok || s_if_pc !== 32'h8000_0040 || s_if_inst !== inst_of(32'h8000_0040)) begin
      failures++;
      $display("FAIL after_drop_inst got ok=%b pc=%h inst=%h want 1/80000040", ok, s_if_pc, s_if_inst);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_stall_hold();
    bit ok;
    int bad = 0;
    logic [31:0] p, ins;
    rdy_en = 1'b1; dly_cfg = 1;
    wait_hold(ok);
    p = s_if_pc; ins = s_if_inst;
    checks++;
    if (!ok || p !== 32'h8000_0044 || ins !== inst_of(32'h8000_0044)) begin
      failures++;
      $display("FAIL stall_fetch got ok=%b pc=%h inst=%h want 1/80000044", ok, p, ins);
    end
    id_stall = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_if_valid !== 1'b1 || s_if_pc !== p || s_if_inst !== ins) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_stable got unstable_cycles=%0d want 0", bad);
    end
    id_stall = 1'b0;
    step();
    if_ready = 1'b0; rdy_en = 1'b0;
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== p + 32'd4) begin
      failures++;
      $display("FAIL stall_release got valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, p + 32'd4);
    end
  endtask

  task automatic test_hold_redirect();
    bit ok;
    rdy_en = 1'b1; dly_cfg = 0;
    wait_hold(ok);
    ie_pc_jump = 1'b1; ie_pc_i = 32'h8000_0300; if_ready = 1'b1;
    step();
    clear_jumps();
    if_ready = 1'b0;
    checks++;
    if (!ok || s_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_redir_valid got ok=%b if_valid=%b want 1/0", ok, s_if_valid);
    end
    rdy_en = 1'b0;
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0300) begin
      failures++;
      $display("FAIL hold_redir_req got valid=%b addr=%h want 1/80000300", s_req_valid, s_req_addr);
    end
    rdy_en = 1'b1;
    wait_hold(ok);
    checks++;
    if (!ok || s_if_pc !== 32'h8000_0300) begin
      failures++;
      $display("FAIL hold_redir_inst got ok=%b pc=%h want 1/80000300", ok, s_if_pc);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    rdy_en = 1'b0;
    ls_pc_jump = 1'b1; ls_pc_i = 32'hFFFF_FFFC;
    step();
    clear_jumps();
    rdy_en = 1'b1;
    wait_hold(ok);
    checks++;
    if (!ok || s_if_pc !== 32'hFFFF_FFFC || s_if_inst !== inst_of(32'hFFFF_FFFC)) begin
      failures++;
      $display("FAIL wrap_fetch got ok=%b pc=%h inst=%h want 1/fffffffc", ok, s_if_pc, s_if_inst);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0; rdy_en = 1'b0;
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_req got valid=%b addr=%h want 1/00000000", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_err();
    bit ok;
    rdy_en = 1'b0;
    id_pc_jump = 1'b1; id_pc_i = 32'hA000_0000;
    step();
    clear_jumps();
    rdy_en = 1'b1;
    wait_hold(ok);
    checks++;
    if (!ok || s_if_err !== 1'b1 || s_if_pc !== 32'hA000_0000 || s_if_inst !== inst_of(32'hA000_0000)) begin
      failures++;
      $display("FAIL err_flag got ok=%b err=%b pc=%h inst=%h want 1/1/a0000000/%h",
               ok, s_if_err, s_if_pc, s_if_inst, inst_of(32'hA000_0000));
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rdy_en = 1'b1; dly_cfg = 5;
    step();
    step();
    rst = 1'b1;
    mem_busy = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL mid_reset got req_valid=%b if_valid=%b addr=%h want 0/0/%h",
               imem_req_valid, if_valid, imem_req_addr, RESET_PC);
    end
    rst = 1'b0;
    #1;
    dly_cfg = 0;
    step();
    step();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL mid_reset_req got valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] model_pc;
    logic        acc;
    int          delivered = 0;
    pulse_reset();
    model_pc = RESET_PC;
    for (int c = 0; c < 1500; c++) begin
      ls_pc_jump = ($urandom_range(0, 24) == 0);
      ie_pc_jump = ($urandom_range(0, 24) == 0);
      id_pc_jump = ($urandom_range(0, 24) == 0);
      ls_pc_i    = $urandom;
      ie_pc_i    = $urandom;
      id_pc_i    = $urandom;
      if_ready   = ($urandom_range(0, 1) == 1);
      id_stall   = ($urandom_range(0, 3) == 0);
      rdy_en     = ($urandom_range(0, 2) != 0);
      dly_cfg    = $urandom_range(0, 3);
      step();
      if (s_req_valid) begin
        checks++;
        if (s_req_addr !== model_pc) begin
          failures++;
          $display("FAIL rand_req_addr cycle=%0d got=%h want=%h", c, s_req_addr, model_pc);
        end
      end
      if (ls_pc_jump || ie_pc_jump || id_pc_jump) begin
        checks++;
        if (s_if_valid !== 1'b0) begin
          failures++;
          $display("FAIL rand_valid_on_redir cycle=%0d got=%b want=0", c, s_if_valid);
        end
      end
      if (s_if_valid) begin
        checks++;
        if (s_if_pc !== model_pc || s_if_inst !== inst_of(model_pc) || s_if_err !== err_of(model_pc)) begin
          failures++;
          $display("FAIL rand_inst cycle=%0d got pc=%h inst=%h err=%b want %h/%h/%b",
                   c, s_if_pc, s_if_inst, s_if_err, model_pc, inst_of(model_pc), err_of(model_pc));
        end
      end
      acc = s_if_valid && if_ready && !id_stall;
      if (acc) delivered++;
      if (ls_pc_jump)      model_pc = ls_pc_i;
      else if (ie_pc_jump) model_pc = ie_pc_i;
      else if (id_pc_jump) model_pc = id_pc_i;
      else if (acc)        model_pc = model_pc + 32'd4;
    end
    clear_jumps();
    if_ready = 1'b0; id_stall = 1'b0;
    checks++;
    if (delivered < 20) begin
      failures++;
      $display("FAIL rand_progress got delivered=%0d want>=20", delivered);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_jumps();
    ls_pc_i = 32'h0; ie_pc_i = 32'h0; id_pc_i = 32'h0;
    if_ready = 1'b0; id_stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_redir_prio();
    test_wait_redirect();
    test_stall_hold();
    test_hold_redirect();
    test_wrap();
    test_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
